// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, PC handshake, hazard controls
// and the IF/ID pipeline register outputs.
interface fetch_stage_if;
  logic [31:0] imemaddr;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        flush;
  logic        pc_adv;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] npc_o;
  logic        valid_o;
  logic        halted;

  modport master (
    input  imemaddr, ihit, imemload, stall, flush,
    output iREN, iaddr, pc_adv, instr_o, pc_o, npc_o, valid_o, halted
  );

  modport slave (
    output imemaddr, ihit, imemload, stall, flush,
    input  iREN, iaddr, pc_adv, instr_o, pc_o, npc_o, valid_o, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the icache, feeds IF/ID through a one-entry
// skid buffer while the hazard unit stalls, and stops on the HALT opcode.
module fetch_stage (
  input logic           CLK,
  input logic           RST,
  fetch_stage_if.master fif
);
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SKID   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [5:0] HALT_OP = 6'b111111;

  state_t      state_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] npc_r;
  logic        valid_r;
  logic        halted_r;
  logic [31:0] skid_instr_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_npc_r;
  logic [31:0] fetch_npc_s;

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr[31:26] == HALT_OP);
  endfunction

  assign fetch_npc_s = fif.imemaddr + 32'd4;

  // The icache is only asked for a word while the skid has room and we are not halted.
  assign fif.iaddr   = fif.imemaddr;
  assign fif.iREN    = (state_r == FETCH);
  assign fif.pc_adv  = (state_r == FETCH) & fif.ihit;
  assign fif.instr_o = instr_r;
  assign fif.pc_o    = pc_r;
  assign fif.npc_o   = npc_r;
  assign fif.valid_o = valid_r;
  assign fif.halted  = halted_r;

  // Fetch state machine, IF/ID register and skid buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= FETCH;
      instr_r      <= 32'd0;
      pc_r         <= 32'd0;
      npc_r        <= 32'd0;
      valid_r      <= 1'b0;
      halted_r     <= 1'b0;
      skid_instr_r <= 32'd0;
      skid_pc_r    <= 32'd0;
      skid_npc_r   <= 32'd0;
    end else if (fif.flush) begin
      state_r      <= FETCH;
      valid_r      <= 1'b0;
      halted_r     <= 1'b0;
      skid_instr_r <= 32'd0;
      skid_pc_r    <= 32'd0;
      skid_npc_r   <= 32'd0;
    end else begin
      case (state_r)
        FETCH: begin
          if (fif.ihit) begin
            if (fif.stall) begin
              skid_instr_r <= fif.imemload;
              skid_pc_r    <= fif.imemaddr;
              skid_npc_r   <= fetch_npc_s;
              state_r      <= SKID;
            end else begin
              instr_r <= fif.imemload;
              pc_r    <= fif.imemaddr;
              npc_r   <= fetch_npc_s;
              valid_r <= 1'b1;
              if (is_halt(fif.imemload)) begin
                state_r  <= HALTED;
                halted_r <= 1'b1;
              end else begin
                state_r <= FETCH;
              end
            end
          end else if (!fif.stall) begin
            valid_r <= 1'b0;
          end else begin
            valid_r <= valid_r;
          end
        end
        SKID: begin
          // A HALT parked in the skid only takes effect once it reaches IF/ID.
          if (!fif.stall) begin
            instr_r      <= skid_instr_r;
            pc_r         <= skid_pc_r;
            npc_r        <= skid_npc_r;
            valid_r      <= 1'b1;
            skid_instr_r <= 32'd0;
            skid_pc_r    <= 32'd0;
            skid_npc_r   <= 32'd0;
            if (is_halt(skid_instr_r)) begin
              state_r  <= HALTED;
              halted_r <= 1'b1;
            end else begin
              state_r <= FETCH;
            end
          end else begin
            state_r <= SKID;
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r  <= FETCH;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
